// File: rtl/nibble_serial_cmp_pkg.sv
// Shared definitions for the serial nibble comparator: FSM states, cascade codes, limits.
// The cascade-input decode is used only when CMP_CASCADE_IN_EN is defined.
package nibble_serial_cmp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned CASC_W      = 3;
   localparam int unsigned NIBBLES_MAX = 16;

   // Cascade code ordering is {gt, eq, lt}
   localparam logic [CASC_W-1:0] CASC_GT = 3'b100;
   localparam logic [CASC_W-1:0] CASC_EQ = 3'b010;
   localparam logic [CASC_W-1:0] CASC_LT = 3'b001;

   // 74HC85 cascade-input decode: EQ dominates, the two illegal combos map to 101 / 000
   function automatic logic [CASC_W-1:0] decode_cascade_in(input logic gt,
                                                           input logic eq,
                                                           input logic lt);
      logic [CASC_W-1:0] code;
      code = CASC_EQ;
      if (!eq) begin
         case ({gt, lt})
            2'b10:   code = CASC_GT;
            2'b01:   code = CASC_LT;
            2'b00:   code = 3'b101;
            default: code = 3'b000;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/nibble_cmp4.sv
// Combinational 4-bit magnitude compare; equal nibbles pass the lower-order cascade through.
module nibble_cmp4
   import nibble_serial_cmp_pkg::*;
(
   input  logic [3:0]        a,
   input  logic [3:0]        b,
   input  logic [CASC_W-1:0] casc_in,
   output logic [CASC_W-1:0] casc_out_c
);

   always_comb begin
      casc_out_c = casc_in;
      if (a > b) begin
         casc_out_c = CASC_GT;
      end else if (a < b) begin
         casc_out_c = CASC_LT;
      end
   end

endmodule

// File: rtl/nibble_serial_cmp.sv
// Serial wide magnitude comparator, operands streamed LSB-nibble first.
// Define CMP_CASCADE_IN_EN to add I_GT/I_EQ/I_LT cascade inputs for chaining instances.
module nibble_serial_cmp
   import nibble_serial_cmp_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       START,
   input  logic       VALID,
   input  logic [3:0] A,
   input  logic [3:0] B,
`ifdef CMP_CASCADE_IN_EN
   input  logic       I_GT,
   input  logic       I_EQ,
   input  logic       I_LT,
`endif
   output logic       Q_GT,
   output logic       Q_EQ,
   output logic       Q_LT,
   output logic       BUSY,
   output logic       DONE
);

   localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CASC_W-1:0] casc_q, casc_d;
   logic [CASC_W-1:0] res_q, res_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [CASC_W-1:0] start_casc;
   logic [CASC_W-1:0] cmp_in;
   logic [CASC_W-1:0] casc_nxt;
   logic [CNT_W-1:0]  cmp_cnt;
   logic              accept;

`ifdef CMP_CASCADE_IN_EN
   assign start_casc = decode_cascade_in(I_GT, I_EQ, I_LT);
`else
   assign start_casc = CASC_EQ;
`endif

   // START overrides the running context so a restart consumes nibble 0 in the same cycle
   always_comb begin
      cmp_in  = casc_q;
      cmp_cnt = cnt_q;
      accept  = 1'b0;
      if (START) begin
         cmp_in  = start_casc;
         cmp_cnt = '0;
         accept  = VALID;
      end else if (state_q == RUN) begin
         accept  = VALID;
      end
   end

   nibble_cmp4 u_cmp (
      .a          (A),
      .b          (B),
      .casc_in    (cmp_in),
      .casc_out_c (casc_nxt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      casc_d  = casc_q;
      res_d   = res_q;
      done_d  = 1'b0;
      if (START) begin
         state_d = RUN;
         cnt_d   = '0;
         casc_d  = start_casc;
      end
      if (accept) begin
         casc_d = casc_nxt;
         if (cmp_cnt == LAST) begin
            res_d   = casc_nxt;
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cmp_cnt + CNT_W'(1);
         end
      end
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         casc_q  <= CASC_EQ;
         res_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         casc_q  <= casc_d;
         res_q   <= res_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign Q_GT = res_q[2];
   assign Q_EQ = res_q[1];
   assign Q_LT = res_q[0];
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_nibble_serial_cmp.sv
// Randomized bench for nibble_serial_cmp against a whole-operand integer compare model.
module tb_nibble_serial_cmp;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   logic       CLK;
   logic       CLR_N;
   logic       START;
   logic       VALID;
   logic [3:0] A;
   logic [3:0] B;
`ifdef CMP_CASCADE_IN_EN
   logic       I_GT;
   logic       I_EQ;
   logic       I_LT;
`endif
   logic       Q_GT;
   logic       Q_EQ;
   logic       Q_LT;
   logic       BUSY;
   logic       DONE;

   int checks     = 0;
   int errors     = 0;
   int done_count = 0;
   int cyc        = 0;

   nibble_serial_cmp #(.NIBBLES(N)) dut (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .START (START),
      .VALID (VALID),
      .A     (A),
      .B     (B),
`ifdef CMP_CASCADE_IN_EN
      .I_GT  (I_GT),
      .I_EQ  (I_EQ),
      .I_LT  (I_LT),
`endif
      .Q_GT  (Q_GT),
      .Q_EQ  (Q_EQ),
      .Q_LT  (Q_LT),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle counter and DONE pulse counter, sampled shortly after each rising edge
   always @(posedge CLK) begin
      #2;
      cyc++;
      if (DONE === 1'b1) done_count++;
   end

   function automatic logic [2:0] qv();
      return {Q_GT, Q_EQ, Q_LT};
   endfunction

   function automatic logic [2:0] init_code();
`ifdef CMP_CASCADE_IN_EN
      case ({I_GT, I_EQ, I_LT})
         3'b100:  return 3'b100;
         3'b001:  return 3'b001;
         3'b000:  return 3'b101;
         3'b101:  return 3'b000;
         default: return 3'b010;
      endcase
`else
      return 3'b010;
`endif
   endfunction

   // Whole-operand compare; equal operands leave the starting cascade unchanged
   function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] init);
      if (a > b) return 3'b100;
      if (a < b) return 3'b001;
      return init;
   endfunction

   task automatic send(input logic st, input logic v, input logic [3:0] a, input logic [3:0] b);
      @(negedge CLK);
      START = st;
      VALID = v;
      A     = a;
      B     = b;
   endtask

   task automatic idle();
      send(1'b0, 1'b0, 4'($urandom), 4'($urandom));
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap_pos, input int gap_len);
      logic [2:0] exp;
      int dc0;
      int c0;
      exp = model(a, b, init_code());
      dc0 = done_count;
      c0  = 0;
      for (int i = 0; i < N; i++) begin
         if (i == gap_pos && i > 0) begin
            for (int g = 0; g < gap_len; g++) begin
               idle();
               checks++;
               if (BUSY !== 1'b1) begin
                  errors++;
                  $display("FAIL %s busy_gap: BUSY=%0b expected 1", name, BUSY);
               end
            end
         end
         send(i == 0, 1'b1, a[4*i +: 4], b[4*i +: 4]);
         if (i == 0) c0 = cyc;
      end
      idle();
      checks++;
      if (DONE !== 1'b1) begin
         errors++;
         $display("FAIL %s done: DONE=%0b expected 1", name, DONE);
      end
      checks++;
      if (qv() !== exp) begin
         errors++;
         $display("FAIL %s result: Q=%03b expected %03b (a=%h b=%h)", name, qv(), exp, a, b);
      end
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_end: BUSY=%0b expected 0", name, BUSY);
      end
      checks++;
      if (done_count != dc0 + 1) begin
         errors++;
         $display("FAIL %s done_count: %0d pulses expected 1", name, done_count - dc0);
      end
      checks++;
      if (cyc - c0 != N + gap_len) begin
         errors++;
         $display("FAIL %s latency: %0d cycles expected %0d", name, cyc - c0, N + gap_len);
      end
      idle();
      checks++;
      if (DONE !== 1'b0 || qv() !== exp) begin
         errors++;
         $display("FAIL %s hold: DONE=%0b Q=%03b expected 0 / %03b", name, DONE, qv(), exp);
      end
   endtask

   task automatic test_reset();
      CLR_N = 1'b0;
      START = 1'b0;
      VALID = 1'b0;
      A     = 4'h0;
      B     = 4'h0;
`ifdef CMP_CASCADE_IN_EN
      I_GT  = 1'b0;
      I_EQ  = 1'b1;
      I_LT  = 1'b0;
`endif
      repeat (2) @(negedge CLK);
      checks++;
      if ({Q_GT, Q_EQ, Q_LT, BUSY, DONE} !== 5'b0) begin
         errors++;
         $display("FAIL reset_in: outputs=%05b expected 00000", {Q_GT, Q_EQ, Q_LT, BUSY, DONE});
      end
      CLR_N = 1'b1;
      repeat (2) idle();
      checks++;
      if ({Q_GT, Q_EQ, Q_LT, BUSY, DONE} !== 5'b0 || done_count != 0) begin
         errors++;
         $display("FAIL reset_out: outputs=%05b dones=%0d expected 00000 / 0",
                  {Q_GT, Q_EQ, Q_LT, BUSY, DONE}, done_count);
      end
   endtask

   task automatic test_directed();
      run_op("eq_1234", 16'h1234, 16'h1234, 0, 0);
      run_op("gt_1235", 16'h1235, 16'h1234, 0, 0);
      run_op("lt_msb_override", 16'h0FFF, 16'h1000, 0, 0);
   endtask

   task automatic test_gap();
      run_op("gap_lt", 16'h1234, 16'h1235, 2, 3);
   endtask

   task automatic test_abort();
      logic [2:0]   prev;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int dc0;
      prev = qv();
      dc0  = done_count;
      x    = W'($urandom);
      y    = W'($urandom);
      a    = 16'hAAAA;
      b    = 16'h5555;
      send(1'b1, 1'b1, x[3:0], y[3:0]);
      send(1'b0, 1'b1, x[7:4], y[7:4]);
      for (int i = 0; i < N; i++) begin
         send(i == 0, 1'b1, a[4*i +: 4], b[4*i +: 4]);
         if (i == 1) begin
            checks++;
            if (qv() !== prev || BUSY !== 1'b1) begin
               errors++;
               $display("FAIL abort_hold: Q=%03b BUSY=%0b expected %03b / 1", qv(), BUSY, prev);
            end
         end
      end
      idle();
      checks++;
      if (DONE !== 1'b1 || qv() !== 3'b100 || done_count != dc0 + 1) begin
         errors++;
         $display("FAIL abort_restart: DONE=%0b Q=%03b pulses=%0d expected 1 / 100 / 1",
                  DONE, qv(), done_count - dc0);
      end
   endtask

   task automatic test_start_final();
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      logic [W-1:0] a2;
      logic [2:0]   exp;
      int dc0;
      a1  = 16'h9000;
      b1  = 16'h0000;
      a2  = W'($urandom);
      exp = model(a2, a2, init_code());
      dc0 = done_count;
      for (int i = 0; i < N - 1; i++) send(i == 0, 1'b1, a1[4*i +: 4], b1[4*i +: 4]);
      send(1'b1, 1'b1, a2[3:0], a2[3:0]);
      send(1'b0, 1'b1, a2[7:4], a2[7:4]);
      checks++;
      if (DONE !== 1'b0 || done_count != dc0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL start_final_nodone: DONE=%0b pulses=%0d BUSY=%0b expected 0 / 0 / 1",
                  DONE, done_count - dc0, BUSY);
      end
      for (int i = 2; i < N; i++) send(1'b0, 1'b1, a2[4*i +: 4], a2[4*i +: 4]);
      idle();
      checks++;
      if (DONE !== 1'b1 || qv() !== exp || done_count != dc0 + 1) begin
         errors++;
         $display("FAIL start_final_result: DONE=%0b Q=%03b pulses=%0d expected 1 / %03b / 1",
                  DONE, qv(), done_count - dc0, exp);
      end
   endtask

   task automatic test_idle_valid();
      logic [2:0] prev;
      int dc0;
      prev = qv();
      dc0  = done_count;
      repeat (6) send(1'b0, 1'b1, 4'($urandom), 4'($urandom));
      idle();
      checks++;
      if (BUSY !== 1'b0 || qv() !== prev || done_count != dc0) begin
         errors++;
         $display("FAIL idle_valid: BUSY=%0b Q=%03b pulses=%0d expected 0 / %03b / 0",
                  BUSY, qv(), done_count - dc0, prev);
      end
   endtask

   task automatic test_clr();
      int dc0;
      dc0 = done_count;
      send(1'b1, 1'b1, 4'h3, 4'h1);
      send(1'b0, 1'b1, 4'h7, 4'h2);
      @(negedge CLK);
      CLR_N = 1'b0;
      START = 1'b0;
      VALID = 1'b0;
      #1;
      checks++;
      if ({Q_GT, Q_EQ, Q_LT, BUSY, DONE} !== 5'b0) begin
         errors++;
         $display("FAIL clr_async: outputs=%05b expected 00000", {Q_GT, Q_EQ, Q_LT, BUSY, DONE});
      end
      @(negedge CLK);
      CLR_N = 1'b1;
      repeat (2) send(1'b0, 1'b1, 4'($urandom), 4'($urandom));
      idle();
      checks++;
      if ({Q_GT, Q_EQ, Q_LT, BUSY, DONE} !== 5'b0 || done_count != dc0) begin
         errors++;
         $display("FAIL clr_discard: outputs=%05b pulses=%0d expected 00000 / 0",
                  {Q_GT, Q_EQ, Q_LT, BUSY, DONE}, done_count - dc0);
      end
      run_op("clr_recover", W'($urandom), W'($urandom), 0, 0);
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int j;
      for (int k = 0; k < 24; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 2))
            0: b = a;
            1: begin
               b = a;
               j = $urandom_range(0, N - 1);
               b[4*j +: 4] = 4'($urandom);
            end
            default: ;
         endcase
         repeat ($urandom_range(0, 2)) idle();
         run_op("random", a, b, $urandom_range(1, N - 1), $urandom_range(0, 3));
      end
   endtask

`ifdef CMP_CASCADE_IN_EN
   task automatic test_cascade();
      logic [W-1:0] a;
      {I_GT, I_EQ, I_LT} = 3'b000;
      a = W'($urandom);
      run_op("casc_000_eq", a, a, 0, 0);
      {I_GT, I_EQ, I_LT} = 3'b101;
      a = W'($urandom);
      run_op("casc_101_eq", a, a, 0, 0);
      for (int k = 0; k < 8; k++) begin
         {I_GT, I_EQ, I_LT} = 3'($urandom);
         a = W'($urandom);
         run_op("casc_random", a, ($urandom_range(0, 1) == 0) ? a : W'($urandom), 0, 0);
      end
      {I_GT, I_EQ, I_LT} = 3'b010;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_gap();
      test_abort();
      test_start_final();
      test_idle_valid();
      test_clr();
      test_random();
`ifdef CMP_CASCADE_IN_EN
      test_cascade();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
